lcd_stream_ctrl: RTL and testbench

//  Parametrised HD44780 character-LCD driver; generalises the fixed-script LCD block. Runs power-up init

---
 rtl/lcd_stream_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_lcd_stream_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_stream_ctrl.sv
// lcd_stream_ctrl
//   HD44780 character-LCD driver. After reset it waits out the panel power-up
//   time, sends the fixed initialisation list, then drains a small FIFO of
//   {rs, byte} writes to the panel. It supports either an 8-bit panel bus or a
//   4-bit bus on lcd_d[7:4] (two nibble strobes per byte).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_valid/wr_rs/      producer write: rs (0 = command, 1 = data) and byte;
//   wr_data/wr_ready     accepted on a clock edge where wr_valid & wr_ready
//   fifo_level           number of queued writes (0..FIFO_DEPTH)
//   init_done            initialisation list finished (sticky until reset)
//   busy                 anything outstanding: init, queued writes, transfer
//   lcd_en/lcd_rs/       panel E strobe, register select, R/W (always write)
//   lcd_rw/lcd_d         and data bus
module lcd_stream_ctrl #(
   parameter int T_POWERUP  = 750_000,
   parameter int T_INIT     = 205_000,
   parameter int T_EN       = 25,
   parameter int T_CMD      = 2_000,
   parameter int T_CLR      = 82_000,
   parameter int FIFO_DEPTH = 8,
   parameter int BUS_4BIT   = 0,
   parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_valid,
   input  logic          wr_rs,
   input  logic [7:0]    wr_data,
   output logic          wr_ready,
   output logic [LW-1:0] fifo_level,
   output logic          init_done,
   output logic          busy,
   output logic          lcd_en,
   output logic          lcd_rs,
   output logic          lcd_rw,
   output logic [7:0]    lcd_d
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int TMAX  = max2(max2(max2(T_POWERUP, T_INIT), max2(T_EN, T_CMD)), T_CLR);
   localparam int CW    = $clog2(TMAX + 1);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int NINIT = (BUS_4BIT != 0) ? 8 : 7;

   typedef enum logic [2:0] {
      S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_GAP, S_PULSE2, S_EXEC
   } state_t;

   // Init list. In 4-bit mode the first four entries are single nibble
   // strobes (only the high nibble is sent) that switch the panel to 4-bit.
   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h30;
      if (BUS_4BIT != 0) begin
         case (idx)
            3'd3:    b = 8'h20;
            3'd4:    b = 8'h28;
            3'd5:    b = 8'h0C;
            3'd6:    b = 8'h01;
            3'd7:    b = 8'h06;
            default: b = 8'h30;
         endcase
      end else begin
         case (idx)
            3'd3:    b = 8'h38;
            3'd4:    b = 8'h0C;
            3'd5:    b = 8'h01;
            3'd6:    b = 8'h06;
            default: b = 8'h30;
         endcase
      end
      return b;
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, lim;
   logic            cnt_done;
   logic [2:0]      idx_q;
   logic            init_done_q;
   logic            rs_q, nib_lo_q;
   logic [7:0]      byte_q;
   logic            pop, push, load_init, init_adv, init_fin, to_gap, nib_only;

   logic [8:0]      fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   count_q;
   logic            fifo_empty;
   logic [8:0]      head;

   assign fifo_empty = (count_q == '0);
   assign wr_ready   = (count_q != LW'(FIFO_DEPTH));
   assign push       = wr_valid & wr_ready;
   assign head       = fifo_mem[rd_ptr_q];
   assign fifo_level = count_q;
   assign init_done  = init_done_q;

   // Nibble-only strobes: the 4-bit wake-up entries of the init list.
   assign nib_only = (BUS_4BIT != 0) && !init_done_q && (idx_q < 3'd4);

   // Terminal count of the current state; zero-length states finish at once.
   always_comb begin
      lim = '0;
      case (state_q)
         S_PWRUP:                  lim = CW'(T_POWERUP - 1);
         S_PULSE, S_GAP, S_PULSE2: lim = CW'(T_EN - 1);
         S_EXEC: begin
            if (!init_done_q && idx_q == 3'd0)
               lim = CW'(T_INIT - 1);
            else if (!rs_q && byte_q[7:2] == 6'd0)
               lim = CW'(T_CLR - 1);    // clear / home take the long wait
            else
               lim = CW'(T_CMD - 1);
         end
         default:                  lim = '0;
      endcase
   end

   assign cnt_done = (cnt_q == lim);
   assign cnt_d    = cnt_done ? '0 : cnt_q + 1'b1;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_PWRUP;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      load_init = 1'b0;
      init_adv  = 1'b0;
      init_fin  = 1'b0;
      to_gap    = 1'b0;
      case (state_q)
         S_PWRUP:  if (cnt_done) state_d = S_INIT;
         S_INIT: begin
            load_init = 1'b1;
            state_d   = S_SETUP;
         end
         S_IDLE: begin
            if (init_done_q && !fifo_empty) begin
               pop     = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP:  state_d = S_PULSE;
         S_PULSE: begin
            if (cnt_done) begin
               if (BUS_4BIT != 0 && !nib_only) begin
                  to_gap  = 1'b1;
                  state_d = S_GAP;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_GAP:    if (cnt_done) state_d = S_PULSE2;
         S_PULSE2: if (cnt_done) state_d = S_EXEC;
         S_EXEC: begin
            if (cnt_done) begin
               if (!init_done_q) begin
                  if (idx_q == 3'(NINIT - 1)) begin
                     init_fin = 1'b1;
                     state_d  = S_IDLE;
                  end else begin
                     init_adv = 1'b1;
                     state_d  = S_INIT;
                  end
               end else if (!fifo_empty) begin
                  // chain straight into the next transfer
                  pop     = 1'b1;
                  state_d = S_SETUP;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default:  state_d = S_PWRUP;
      endcase
   end

   // Outputs
   always_comb begin
      lcd_en = (state_q == S_PULSE) || (state_q == S_PULSE2);
      lcd_rs = rs_q;
      lcd_rw = 1'b0;
      lcd_d  = (BUS_4BIT != 0) ? {(nib_lo_q ? byte_q[3:0] : byte_q[7:4]), 4'b0000} : byte_q;
      busy   = !((state_q == S_IDLE) && init_done_q && fifo_empty);
   end

   // Datapath and FIFO control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         rs_q        <= 1'b0;
         byte_q      <= '0;
         nib_lo_q    <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (load_init) begin
            rs_q     <= 1'b0;
            byte_q   <= init_byte(idx_q);
            nib_lo_q <= 1'b0;
         end else if (pop) begin
            rs_q     <= head[8];
            byte_q   <= head[7:0];
            nib_lo_q <= 1'b0;
         end else if (to_gap) begin
            nib_lo_q <= 1'b1;     // low nibble goes out on the second strobe
         end
         if (init_adv) idx_q <= idx_q + 3'd1;
         if (init_fin) init_done_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + LW'(push) - LW'(pop);
      end
   end

   // Queue storage; no reset needed, contents are qualified by count_q.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {wr_rs, wr_data};
   end

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Bench for lcd_stream_ctrl: one 8-bit and one 4-bit instance. Stimulus pushes
// the expected panel strobes into a queue; a monitor measures every strobe
// (rs, data, E-high width, E-low time until the next strobe or until busy
// drops) and compares it with the head of the queue.
module tb_lcd_stream_ctrl;
   localparam int T_POWERUP = 20;
   localparam int T_INIT    = 10;
   localparam int T_EN      = 2;
   localparam int T_CMD     = 5;
   localparam int T_CLR     = 15;
   localparam int DEPTH     = 4;
   localparam int LW        = $clog2(DEPTH + 1);

   typedef struct {
      int         unit;
      logic       rs;
      logic [7:0] d;
      int         lo_min;
      int         lo_max;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n      [2];
   logic          wr_valid   [2];
   logic          wr_rs      [2];
   logic [7:0]    wr_data    [2];
   logic          wr_ready   [2];
   logic [LW-1:0] fifo_level [2];
   logic          init_done  [2];
   logic          busy       [2];
   logic          lcd_en     [2];
   logic          lcd_rs     [2];
   logic          lcd_rw     [2];
   logic [7:0]    lcd_d      [2];

   always #5 clk = ~clk;

   lcd_stream_ctrl #(.T_POWERUP(T_POWERUP), .T_INIT(T_INIT), .T_EN(T_EN), .T_CMD(T_CMD),
                     .T_CLR(T_CLR), .FIFO_DEPTH(DEPTH), .BUS_4BIT(0)) u_dut8 (
      .clk(clk), .rst_n(rst_n[0]), .wr_valid(wr_valid[0]), .wr_rs(wr_rs[0]),
      .wr_data(wr_data[0]), .wr_ready(wr_ready[0]), .fifo_level(fifo_level[0]),
      .init_done(init_done[0]), .busy(busy[0]), .lcd_en(lcd_en[0]), .lcd_rs(lcd_rs[0]),
      .lcd_rw(lcd_rw[0]), .lcd_d(lcd_d[0]));

   lcd_stream_ctrl #(.T_POWERUP(T_POWERUP), .T_INIT(T_INIT), .T_EN(T_EN), .T_CMD(T_CMD),
                     .T_CLR(T_CLR), .FIFO_DEPTH(DEPTH), .BUS_4BIT(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n[1]), .wr_valid(wr_valid[1]), .wr_rs(wr_rs[1]),
      .wr_data(wr_data[1]), .wr_ready(wr_ready[1]), .fifo_level(fifo_level[1]),
      .init_done(init_done[1]), .busy(busy[1]), .lcd_en(lcd_en[1]), .lcd_rs(lcd_rs[1]),
      .lcd_rw(lcd_rw[1]), .lcd_d(lcd_d[1]));

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   // monitor state per unit
   bit         pend[2];
   bit         pen[2];
   bit         unstable[2];
   int         hi[2];
   int         lo[2];
   logic       crs[2];
   logic [7:0] cd[2];

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic expect_pulse(input int u, input logic rs, input logic [7:0] d,
                               input int lmin, input int lmax);
      exp_t e;
      e.unit = u; e.rs = rs; e.d = d; e.lo_min = lmin; e.lo_max = lmax;
      exp_q.push_back(e);
   endtask

   // Init strobes. The E-low time after an init strobe also includes the
   // fetch of the next list entry and its setup cycle, hence the +2 window.
   task automatic expect_init(input int u);
      logic [7:0] b8 [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
      int         w8 [7] = '{T_INIT, T_CMD, T_CMD, T_CMD, T_CMD, T_CLR, T_CMD};
      logic [7:0] b4 [4] = '{8'h28, 8'h0C, 8'h01, 8'h06};
      int         w4 [4] = '{T_CMD, T_CMD, T_CLR, T_CMD};
      logic [7:0] n4 [4] = '{8'h30, 8'h30, 8'h30, 8'h20};
      int         wn [4] = '{T_INIT, T_CMD, T_CMD, T_CMD};
      if (u == 0) begin
         for (int i = 0; i < 7; i++) expect_pulse(0, 1'b0, b8[i], w8[i], w8[i] + 2);
      end else begin
         for (int i = 0; i < 4; i++) expect_pulse(1, 1'b0, n4[i], wn[i], wn[i] + 2);
         for (int i = 0; i < 4; i++) begin
            expect_pulse(1, 1'b0, {b4[i][7:4], 4'h0}, T_EN, T_EN);
            expect_pulse(1, 1'b0, {b4[i][3:0], 4'h0}, w4[i], w4[i] + 2);
         end
      end
   endtask

   task automatic finalize(input int u);
      exp_t e;
      pend[u] = 1'b0;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL pulse_unexpected: unit %0d got rs=%0b d=0x%02h, required no strobe",
                  u, crs[u], cd[u]);
         return;
      end
      e = exp_q.pop_front();
      if (e.unit != u || e.rs !== crs[u] || e.d !== cd[u] || hi[u] != T_EN ||
          lo[u] < e.lo_min || lo[u] > e.lo_max || unstable[u]) begin
         n_fail++;
         $display("FAIL pulse: unit %0d got rs=%0b d=0x%02h en_hi=%0d en_lo=%0d unstable=%0b, required unit %0d rs=%0b d=0x%02h en_hi=%0d en_lo=%0d..%0d stable",
                  u, crs[u], cd[u], hi[u], lo[u], unstable[u],
                  e.unit, e.rs, e.d, T_EN, e.lo_min, e.lo_max);
      end else begin
         $display("pulse unit %0d rs=%0b d=0x%02h en_hi=%0d en_lo=%0d ok",
                  u, crs[u], cd[u], hi[u], lo[u]);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      for (int u = 0; u < 2; u++) begin
         pend[u] = 1'b0; pen[u] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            if (!rst_n[u]) begin
               pend[u] = 1'b0;
               pen[u]  = 1'b0;
            end else begin
               if (lcd_en[u]) begin
                  if (!pen[u]) begin
                     if (pend[u]) finalize(u);
                     crs[u] = lcd_rs[u]; cd[u] = lcd_d[u];
                     hi[u] = 1; unstable[u] = (lcd_rw[u] !== 1'b0);
                  end else begin
                     hi[u]++;
                     if (lcd_rs[u] !== crs[u] || lcd_d[u] !== cd[u] || lcd_rw[u] !== 1'b0)
                        unstable[u] = 1'b1;
                  end
               end else begin
                  if (pen[u]) begin
                     pend[u] = 1'b1;
                     lo[u]   = 0;
                  end
                  if (pend[u]) begin
                     if (!busy[u]) finalize(u);
                     else lo[u]++;
                  end
               end
               pen[u] = lcd_en[u];
            end
         end
      end
   end

   task automatic push(input int u, input logic rs, input logic [7:0] d);
      int t = 0;
      wr_valid[u] = 1'b1; wr_rs[u] = rs; wr_data[u] = d;
      while (!wr_ready[u] && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         n_cmp++; n_fail++;
         $display("FAIL push_timeout: unit %0d got wr_ready=0 for %0d cycles, required acceptance", u, t);
      end
      @(negedge clk);
      wr_valid[u] = 1'b0;
   endtask

   task automatic wait_idle(input int u, input string name);
      int t = 0;
      while (!(init_done[u] && !busy[u]) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         n_cmp++; n_fail++;
         $display("FAIL %s: got busy after %0d cycles, required idle", name, t);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      for (int u = 0; u < 2; u++) begin
         rst_n[u] = 1'b0; wr_valid[u] = 1'b0; wr_rs[u] = 1'b0; wr_data[u] = 8'h00;
      end
      repeat (3) @(negedge clk);

      // reset state
      check("rst_en",        int'(lcd_en[0]), 0);
      check("rst_rs",        int'(lcd_rs[0]), 0);
      check("rst_d",         int'(lcd_d[0]), 0);
      check("rst_rw",        int'(lcd_rw[0]), 0);
      check("rst_init_done", int'(init_done[0]), 0);
      check("rst_busy",      int'(busy[0]), 1);
      check("rst_level",     int'(fifo_level[0]), 0);
      check("rst_wr_ready",  int'(wr_ready[0]), 1);
      check("rst_busy4",     int'(busy[1]), 1);

      // power-up and init, 8-bit bus
      expect_init(0);
      rst_n[0] = 1'b1;
      t = 0;
      while (!lcd_en[0] && t < 200) begin
         @(negedge clk);
         if (!lcd_en[0]) t++;
      end
      // idle span before first E: at least T_POWERUP, plus list fetch/setup
      check("pwrup_delay_ok", int'(t >= T_POWERUP && t <= T_POWERUP + 3), 1);
      wait_idle(0, "init8_idle");
      check("init_done", int'(init_done[0]), 1);
      check("init_busy", int'(busy[0]), 0);
      check("init8_drained", exp_q.size(), 0);

      // single data write from idle
      expect_pulse(0, 1'b1, 8'h41, T_CMD, T_CMD);
      push(0, 1'b1, 8'h41);
      @(negedge clk);
      check("setup_d",  int'(lcd_d[0]), 'h41);
      check("setup_rs", int'(lcd_rs[0]), 1);
      check("setup_en", int'(lcd_en[0]), 0);
      wait_idle(0, "char_idle");

      // clear then set-address: 0x01 chains into 0x80 (T_CLR exec + 1 setup)
      expect_pulse(0, 1'b0, 8'h01, T_CLR + 1, T_CLR + 1);
      expect_pulse(0, 1'b0, 8'h80, T_CMD, T_CMD);
      push(0, 1'b0, 8'h01);
      push(0, 1'b0, 8'h80);
      wait_idle(0, "clr_idle");

      // five writes during power-up: FIFO fills at four
      rst_n[0] = 1'b0;
      @(negedge clk);
      expect_init(0);
      expect_pulse(0, 1'b1, 8'h48, T_CMD + 1, T_CMD + 1);
      expect_pulse(0, 1'b1, 8'h45, T_CMD + 1, T_CMD + 1);
      expect_pulse(0, 1'b1, 8'h4C, T_CMD + 1, T_CMD + 1);
      expect_pulse(0, 1'b1, 8'h4C, T_CMD + 1, T_CMD + 1);
      expect_pulse(0, 1'b1, 8'h4F, T_CMD, T_CMD);
      rst_n[0] = 1'b1;
      push(0, 1'b1, 8'h48);
      push(0, 1'b1, 8'h45);
      push(0, 1'b1, 8'h4C);
      push(0, 1'b1, 8'h4C);
      check("full_level",    int'(fifo_level[0]), 4);
      check("full_wr_ready", int'(wr_ready[0]), 0);
      check("full_init",     int'(init_done[0]), 0);
      push(0, 1'b1, 8'h4F);
      wait_idle(0, "burst_idle");
      check("burst_drained", exp_q.size(), 0);

      // reset in the middle of an E pulse with three writes queued
      rst_n[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      push(0, 1'b1, 8'h58);
      push(0, 1'b1, 8'h59);
      push(0, 1'b1, 8'h5A);
      check("mid_level", int'(fifo_level[0]), 3);
      t = 0;
      while (!lcd_en[0] && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("mid_en_seen", int'(lcd_en[0]), 1);
      #1 rst_n[0] = 1'b0;
      #1;
      check("mid_en_drop",   int'(lcd_en[0]), 0);
      check("mid_level0",    int'(fifo_level[0]), 0);
      check("mid_wr_ready",  int'(wr_ready[0]), 1);
      check("mid_init_done", int'(init_done[0]), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      expect_init(0);
      rst_n[0] = 1'b1;
      wait_idle(0, "rerun_idle");
      check("rerun_drained", exp_q.size(), 0);

      // 4-bit bus: nibble wake-up, byte init, then one data byte
      expect_init(1);
      rst_n[1] = 1'b1;
      wait_idle(1, "init4_idle");
      check("init4_drained", exp_q.size(), 0);
      expect_pulse(1, 1'b1, 8'h50, T_EN, T_EN);
      expect_pulse(1, 1'b1, 8'hB0, T_CMD, T_CMD);
      push(1, 1'b1, 8'h5B);
      wait_idle(1, "nib_idle");
      check("final_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
